fpu_issue_ctrl: RTL
===================

Name: fpu_issue_ctrl

Overview:
- Sequences one decoded RV32F operation at a time into the shared FPU core.
- Issue handshake: takes `apu_op`/`rnd`/register indices from the decoder stage and holds the core pipeline via `issue_ready`.
- Drives the FPU request/grant/response protocol and routes the result to the float or integer register-file write port.
- Accumulates sticky fflags.
- Sits between the FP decoder and the FPU, beside the integer writeback mux.

Parameters:
- TIMEOUT_CYCLES, 64, cycles allowed in WAIT before `timeout_err` is raised (minimum 2).
- CNT_W, 7, width of the latency counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  decoded FP op present (decoder `fpu_enable` qualified by pipeline valid).
- issue_ready  out  1  controller accepts the op this cycle.
- issue_apu_op  in  5  {op_mod, fp_op} from decoder.
- issue_rnd  in  3  rounding mode.
- issue_rd  in  5  destination register index.
- issue_rd_int  in  1  1 = result goes to integer RF (CMP, F2I, CLASSIFY, FMV.X.W).
- flush  in  1  kill current op (branch/exception); result must be discarded.
- apu_req  out  1  request to FPU.
- apu_op  out  5  registered op to FPU.
- apu_rnd  out  3  registered rounding mode.
- apu_gnt  in  1  FPU accepted request.
- apu_rvalid  in  1  FPU result valid (single-cycle pulse).
- apu_result  in  32  FPU result.
- apu_flags  in  5  NV, DZ, OF, UF, NX.
- wb_valid  out  1  writeback request.
- wb_ready  in  1  writeback port free this cycle.
- wb_rd  out  5  writeback register index.
- wb_data  out  32  writeback data.
- wb_to_int  out  1  1 = integer RF, 0 = float RF.
- fflags  out  5  sticky accumulated exception flags.
- fflags_clr  in  1  clear fflags (CSR write).
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky; set when WAIT exceeds TIMEOUT_CYCLES.

Behaviour:
- Reset values: all outputs 0; state = IDLE; latency counter 0.

States: IDLE, REQ, WAIT, WB, DRAIN.
- IDLE:
  - `issue_ready` = 1 (combinational, IDLE only).
  - On `issue_valid && !flush`: latch op, rnd, rd, rd_int; go to REQ next cycle.
  - Latency from accept to `apu_req` high is 1 cycle.
- REQ:
  - `apu_req` = 1; `apu_op`/`apu_rnd` stable until `apu_gnt`.
  - On `gnt`: go to WAIT and clear the counter.
  - On `flush` with `!gnt`: drop `req` and go to IDLE (nothing outstanding).
  - On `flush && gnt` in the same cycle: go to DRAIN.
- WAIT:
  - Counter increments each cycle, saturating at TIMEOUT_CYCLES.
  - When counter == TIMEOUT_CYCLES: set `timeout_err`; remain in WAIT.
  - On `apu_rvalid`: capture result and flags into the wb register; OR `apu_flags` into `fflags`; go to WB.
  - `rvalid` on the same cycle as `gnt` is legal only in REQ. Capture it there and go directly to WB, skipping WAIT.
  - `flush` in WAIT: go to DRAIN.
- DRAIN:
  - Wait for `apu_rvalid`, discard result and flags, then go to IDLE.
  - `flush` again in DRAIN has no effect.
- WB:
  - `wb_valid` = 1 with `wb_rd`, `wb_data`, `wb_to_int` held stable until `wb_ready`.
  - On `wb_ready`: go to IDLE; `wb_valid` drops next cycle.
  - `flush` in WB: drop `wb_valid`, go to IDLE, no write.
  - Flags already accumulated are kept, because they were raised by the earlier `rvalid` capture.
- Back-to-back: next op can be accepted in the cycle after WB exits. Minimum 4-cycle initiation interval with a 1-cycle FPU.
- fflags:
  - `fflags_clr` has priority over a same-cycle accumulate; flags arriving that cycle are lost.
  - Flags from a DRAINed op are never accumulated.
- Counter width rule: compare at CNT_W bits; no wrap (saturating).
- `apu_rvalid` in IDLE or WB is a protocol violation and is ignored.
- `rst_n` low mid-operation returns to IDLE immediately; no writeback issued.

Decomposition:
- Shared package fpu_ctrl_pkg holds:
  - the FSM state enum;
  - the fp_operations_e and fpu_opcodes_e enums, moved out of the decoder so both blocks share them;
  - fflags bit-position constants.
- No sub-module; the single FSM plus counter is natural as one module.

Test Plan:
- ADD issue (op=5'b00010, rd=3, rd_int=0), `gnt` immediate, `rvalid` 3 cycles later with result 0x40400000, flags=00001, `wb_ready`=1:
  - `wb_valid` for 1 cycle with wb_rd=3, wb_data=0x40400000, wb_to_int=0;
  - fflags=00001;
  - `issue_ready` back high the cycle after.
- F2I (op=5'b01011, rd=7, rd_int=1), `wb_ready` held low 5 cycles:
  - `wb_valid` and data stable all 5 cycles;
  - `wb_to_int`=1;
  - single write on release.
- `flush` asserted 1 cycle after `gnt`, then `rvalid` with flags=10000:
  - no `wb_valid`;
  - fflags unchanged (0);
  - returns to IDLE after `rvalid`.
- `gnt` withheld 4 cycles then `flush` in REQ:
  - `apu_req` drops next cycle;
  - IDLE;
  - no DRAIN wait.
- TIMEOUT_CYCLES=8, no `rvalid`:
  - `timeout_err` rises 8 cycles after `gnt` and stays set;
  - a later `rvalid` still completes writeback.
- `fflags_clr` coincident with `rvalid` (flags=00100):
  - fflags=0 afterward;
  - async `rst_n` pulse in WAIT sets all outputs to 0 within the same cycle.

Source files
------------

// File: rtl/fpu_ctrl_pkg.sv
// fpu_ctrl_pkg: shared FSM encodings, RV32F operation/opcode enums and fflags bit positions
package fpu_ctrl_pkg;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_WB    = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_REQ   = ST_REQ,
    S_WAIT  = ST_WAIT,
    S_WB    = ST_WB,
    S_DRAIN = ST_DRAIN
  } fsm_state_e;
  typedef enum logic [3:0] {
    FMADD, FNMSUB, FADD, FMUL, FDIV, FSQRT, FSGNJ, FMINMAX,
    FCMP, FCLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } fp_operations_e;
  typedef enum logic [6:0] {
    OPC_LOAD_FP  = 7'h07,
    OPC_STORE_FP = 7'h27,
    OPC_FMADD    = 7'h43,
    OPC_FMSUB    = 7'h47,
    OPC_FNMSUB   = 7'h4b,
    OPC_FNMADD   = 7'h4f,
    OPC_OP_FP    = 7'h53
  } fpu_opcodes_e;
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;
endpackage

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issues one decoded RV32F op at a time to the shared FPU and writes back its result
// Ports: issue_* decoder handshake; apu_* FPU request/grant/response; wb_* register-file write port;
// fflags/fflags_clr sticky exception flags; flush kills the current op; busy/timeout_err status.
module fpu_issue_ctrl
  import fpu_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [4:0]  issue_apu_op,
  input  logic [2:0]  issue_rnd,
  input  logic [4:0]  issue_rd,
  input  logic        issue_rd_int,
  input  logic        flush,
  output logic        apu_req,
  output logic [4:0]  apu_op,
  output logic [2:0]  apu_rnd,
  input  logic        apu_gnt,
  input  logic        apu_rvalid,
  input  logic [31:0] apu_result,
  input  logic [4:0]  apu_flags,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_to_int,
  output logic [4:0]  fflags,
  input  logic        fflags_clr,
  output logic        busy,
  output logic        timeout_err
);
  localparam logic [CNT_W-1:0] T_MAX = CNT_W'(TIMEOUT_CYCLES);
  logic [2:0]       state, state_d;
  logic [CNT_W-1:0] cnt;
  logic             accept, capture;
  assign accept      = state == ST_IDLE && issue_valid && !flush;
  assign capture     = state_d == ST_WB && state != ST_WB;
  // gated by rst_n so every output reads 0 while reset is held
  assign issue_ready = rst_n && state == ST_IDLE;
  assign apu_req     = state == ST_REQ;
  assign wb_valid    = state == ST_WB;
  assign busy        = state != ST_IDLE;
  // a granted REQ behaves like WAIT, so a same-cycle rvalid skips WAIT;
  // flush together with rvalid discards the result straight away instead of draining
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:         state_d = accept ? ST_REQ : ST_IDLE;
      ST_REQ, ST_WAIT: state_d = (state == ST_REQ && !apu_gnt) ? (flush ? ST_IDLE : ST_REQ)
                               : flush ? (apu_rvalid ? ST_IDLE : ST_DRAIN)
                               : apu_rvalid ? ST_WB : ST_WAIT;
      ST_DRAIN:        state_d = apu_rvalid ? ST_IDLE : ST_DRAIN;
      ST_WB:           state_d = (flush || wb_ready) ? ST_IDLE : ST_WB;
      default:         state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      apu_op      <= '0;
      apu_rnd     <= '0;
      wb_rd       <= '0;
      wb_to_int   <= 1'b0;
      wb_data     <= '0;
      fflags      <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        apu_op    <= issue_apu_op;
        apu_rnd   <= issue_rnd;
        wb_rd     <= issue_rd;
        wb_to_int <= issue_rd_int;
      end
      if (capture) wb_data <= apu_result;
      cnt <= state == ST_REQ ? '0 : (state == ST_WAIT && cnt != T_MAX) ? cnt + 1'b1 : cnt;
      // raised on the edge where the counter reaches the limit
      if (state == ST_WAIT && cnt == T_MAX - 1'b1) timeout_err <= 1'b1;
      fflags <= fflags_clr ? '0 : capture ? (fflags | apu_flags) : fflags;
    end
  end
endmodule
